// File: rtl/mio_pkg.sv
// Shared definitions for the memory/IO bus responder: state encoding,
// IO region decode constant and the wait-count clamp helper.
package mio_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      DONE   = 2'd3
   } mio_state_t;

   localparam logic [2:0] IO_REGION_HI = 3'b111;

   // A zero wait would leave no cycle for the synchronous RAM read to land
   function automatic int eff_wait(input int w);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/mio_responder_if.sv
// CPU-side request/response bundle between the controller (master)
// and the memory/IO responder (slave).
interface mio_responder_if;

   logic        CPU_MIO;
   logic        mem_w;
   logic [31:0] addr_bus;
   logic [31:0] Data_out;
   logic [31:0] Data_in;
   logic        MIO_ready;

   modport master (
      output CPU_MIO, mem_w, addr_bus, Data_out,
      input  Data_in, MIO_ready
   );

   modport slave (
      input  CPU_MIO, mem_w, addr_bus, Data_out,
      output Data_in, MIO_ready
   );

endinterface

// File: rtl/mio_wait_timer.sv
// Loadable down-counter that saturates at zero; zero flags the final
// wait cycle of the access currently in flight.
module mio_wait_timer #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/mio_responder.sv
// Memory/IO responder: accepts one CPU request, strobes RAM or IO once,
// waits a per-region number of cycles, then completes a 4-phase handshake.
module mio_responder
   import mio_pkg::*;
#(
   parameter int RAM_AW   = 10,
   parameter int RAM_WAIT = 1,
   parameter int IO_WAIT  = 3
) (
   input  logic              clk,
   input  logic              rst,
   mio_responder_if.slave    bus,
   output logic              ram_en,
   output logic              ram_we,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [31:0]       ram_din,
   input  logic [31:0]       ram_dout,
   output logic              io_en,
   output logic              io_we,
   output logic [31:0]       io_addr,
   output logic [31:0]       io_wdata,
   input  logic [31:0]       io_rdata
);

   localparam int RAM_N = eff_wait(RAM_WAIT);
   localparam int IO_N  = eff_wait(IO_WAIT);
   localparam int MAX_N = (RAM_N > IO_N) ? RAM_N : IO_N;
   localparam int CW    = $clog2(MAX_N + 1);

   mio_state_t        state, state_nxt;
   logic              we_q, we_nxt;
   logic              io_sel_q, io_sel_nxt;
   logic [31:0]       data_in_q, data_in_nxt;
   logic              mio_ready_q, mio_ready_nxt;
   logic              ram_en_nxt, ram_we_nxt, io_en_nxt, io_we_nxt;
   logic [RAM_AW-1:0] ram_addr_nxt;
   logic [31:0]       ram_din_nxt, io_addr_nxt, io_wdata_nxt;
   logic              is_io;
   logic              timer_load, timer_dec, timer_zero;
   logic [CW-1:0]     timer_val;

   assign is_io = (bus.addr_bus[31:29] == IO_REGION_HI);

   // The timer holds N-1 so that its zero flag marks the last of N wait cycles
   mio_wait_timer #(.W(CW)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (timer_load),
      .load_val (timer_val),
      .dec      (timer_dec),
      .zero     (timer_zero)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         we_q        <= 1'b0;
         io_sel_q    <= 1'b0;
         data_in_q   <= '0;
         mio_ready_q <= 1'b0;
         ram_en      <= 1'b0;
         ram_we      <= 1'b0;
         ram_addr    <= '0;
         ram_din     <= '0;
         io_en       <= 1'b0;
         io_we       <= 1'b0;
         io_addr     <= '0;
         io_wdata    <= '0;
      end else begin
         state       <= state_nxt;
         we_q        <= we_nxt;
         io_sel_q    <= io_sel_nxt;
         data_in_q   <= data_in_nxt;
         mio_ready_q <= mio_ready_nxt;
         ram_en      <= ram_en_nxt;
         ram_we      <= ram_we_nxt;
         ram_addr    <= ram_addr_nxt;
         ram_din     <= ram_din_nxt;
         io_en       <= io_en_nxt;
         io_we       <= io_we_nxt;
         io_addr     <= io_addr_nxt;
         io_wdata    <= io_wdata_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      we_nxt       = we_q;
      io_sel_nxt   = io_sel_q;
      data_in_nxt  = data_in_q;
      ram_en_nxt   = 1'b0;
      ram_we_nxt   = 1'b0;
      io_en_nxt    = 1'b0;
      io_we_nxt    = 1'b0;
      ram_addr_nxt = ram_addr;
      ram_din_nxt  = ram_din;
      io_addr_nxt  = io_addr;
      io_wdata_nxt = io_wdata;
      timer_load   = 1'b0;
      timer_dec    = 1'b0;
      timer_val    = '0;

      unique case (state)
         IDLE: begin
            if (bus.CPU_MIO) begin
               we_nxt       = bus.mem_w;
               io_sel_nxt   = is_io;
               ram_en_nxt   = !is_io;
               ram_we_nxt   = !is_io && bus.mem_w;
               io_en_nxt    = is_io;
               io_we_nxt    = is_io && bus.mem_w;
               ram_addr_nxt = bus.addr_bus[RAM_AW+1:2];
               ram_din_nxt  = bus.Data_out;
               io_addr_nxt  = bus.addr_bus;
               io_wdata_nxt = bus.Data_out;
               timer_load   = 1'b1;
               timer_val    = is_io ? CW'(IO_N - 1) : CW'(RAM_N - 1);
               state_nxt    = ACCESS;
            end
         end
         ACCESS: begin
            state_nxt = WAIT;
         end
         WAIT: begin
            if (timer_zero) begin
               data_in_nxt = we_q ? 32'd0 : (io_sel_q ? io_rdata : ram_dout);
               state_nxt   = DONE;
            end else begin
               timer_dec = 1'b1;
            end
         end
         DONE: begin
            if (!bus.CPU_MIO) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase

      mio_ready_nxt = (state_nxt == DONE);
   end

   assign bus.Data_in   = data_in_q;
   assign bus.MIO_ready = mio_ready_q;

endmodule

// File: tb/tb_mio_responder.sv
// Scoreboard bench for mio_responder: directed requests push expected load data
// and completion cycle; a negedge monitor pops them when MIO_ready rises.
module tb_mio_responder;

   typedef struct {
      logic [31:0] data;
      int          cyc;
   } exp_t;

   typedef struct {
      bit          is_io;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } strobe_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   checks = 0;
   int   passes = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mio_responder_if bus1();
   mio_responder_if bus2();

   logic        ram_en1, ram_we1, io_en1, io_we1;
   logic [9:0]  ram_addr1;
   logic [31:0] ram_din1, ram_dout1, io_addr1, io_wdata1, io_rdata1;
   logic        ram_en2, ram_we2, io_en2, io_we2;
   logic [9:0]  ram_addr2;
   logic [31:0] ram_din2, ram_dout2, io_addr2, io_wdata2, io_rdata2;

   mio_responder dut1 (
      .clk(clk), .rst(rst), .bus(bus1),
      .ram_en(ram_en1), .ram_we(ram_we1), .ram_addr(ram_addr1), .ram_din(ram_din1),
      .ram_dout(ram_dout1), .io_en(io_en1), .io_we(io_we1), .io_addr(io_addr1),
      .io_wdata(io_wdata1), .io_rdata(io_rdata1)
   );

   mio_responder #(.RAM_WAIT(0)) dut2 (
      .clk(clk), .rst(rst), .bus(bus2),
      .ram_en(ram_en2), .ram_we(ram_we2), .ram_addr(ram_addr2), .ram_din(ram_din2),
      .ram_dout(ram_dout2), .io_en(io_en2), .io_we(io_we2), .io_addr(io_addr2),
      .io_wdata(io_wdata2), .io_rdata(io_rdata2)
   );

   // Synchronous RAM models with one-cycle read latency
   logic [31:0] mem1 [0:1023];

   always @(posedge clk) begin
      if (ram_en1) begin
         if (ram_we1) mem1[ram_addr1] <= ram_din1;
         ram_dout1 <= mem1[ram_addr1];
      end
      if (ram_en2) ram_dout2 <= {16'h5A5A, 6'd0, ram_addr2};
   end

   exp_t    exp_q1[$];
   exp_t    exp_q2[$];
   strobe_t log1[$];
   exp_t    e1, e2;
   logic    rdy1_prev = 1'b0;
   logic    rdy2_prev = 1'b0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   always @(negedge clk) begin
      if (bus1.MIO_ready && !rdy1_prev) begin
         if (exp_q1.size() == 0) begin
            checks++;
            $display("[TB] FAIL dut1_unexpected_ready: got MIO_ready=1, expected 0");
         end else begin
            e1 = exp_q1.pop_front();
            checkOutput("dut1_data", bus1.Data_in, e1.data);
            checkOutput("dut1_ready_cycle", 32'(cyc), 32'(e1.cyc));
         end
      end
      rdy1_prev = bus1.MIO_ready;
      if (ram_en1) log1.push_back(strobe_t'{1'b0, ram_we1, 32'(ram_addr1), ram_din1});
      if (io_en1)  log1.push_back(strobe_t'{1'b1, io_we1, io_addr1, io_wdata1});
   end

   always @(negedge clk) begin
      if (bus2.MIO_ready && !rdy2_prev) begin
         if (exp_q2.size() == 0) begin
            checks++;
            $display("[TB] FAIL dut2_unexpected_ready: got MIO_ready=1, expected 0");
         end else begin
            e2 = exp_q2.pop_front();
            checkOutput("dut2_data", bus2.Data_in, e2.data);
            checkOutput("dut2_ready_cycle", 32'(cyc), 32'(e2.cyc));
         end
      end
      rdy2_prev = bus2.MIO_ready;
   end

   task automatic drive_bus(input int which, input logic req, input logic w,
                            input logic [31:0] a, input logic [31:0] d);
      if (which == 1) begin
         bus1.CPU_MIO = req; bus1.mem_w = w; bus1.addr_bus = a; bus1.Data_out = d;
      end else begin
         bus2.CPU_MIO = req; bus2.mem_w = w; bus2.addr_bus = a; bus2.Data_out = d;
      end
   endtask

   function automatic logic ready_of(input int which);
      return (which == 1) ? bus1.MIO_ready : bus2.MIO_ready;
   endfunction

   function automatic logic [31:0] data_of(input int which);
      return (which == 1) ? bus1.Data_in : bus2.Data_in;
   endfunction

   // Called at a negedge; returns at the negedge where MIO_ready must be low again
   task automatic applyStimulus(input int which, input logic w, input logic [31:0] a,
                                input logic [31:0] d, input logic [31:0] expd,
                                input int n, input bit drop_early);
      exp_t e;
      bit   seen;
      e.data = expd;
      e.cyc  = cyc + 2 + n;
      if (which == 1) exp_q1.push_back(e);
      else            exp_q2.push_back(e);
      drive_bus(which, 1'b1, w, a, d);
      @(negedge clk);
      drive_bus(which, !drop_early, ~w, ~a, ~d);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (ready_of(which)) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!seen) begin
         checks++;
         $display("[TB] FAIL ready_timeout: got no MIO_ready within 40 cycles, expected one");
      end else if (!drop_early) begin
         @(negedge clk);
         checkOutput("ready_hold", 32'(ready_of(which)), 32'd1);
         checkOutput("data_hold", data_of(which), expd);
      end
      drive_bus(which, 1'b0, ~w, ~a, ~d);
      @(negedge clk);
      checkOutput("ready_drop", 32'(ready_of(which)), 32'd0);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got simulation still running, expected $finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1;
      io_rdata1 = 32'd0;
      io_rdata2 = 32'd0;
      drive_bus(1, 1'b0, 1'b0, 32'd0, 32'd0);
      drive_bus(2, 1'b0, 1'b0, 32'd0, 32'd0);
      for (int i = 0; i < 1024; i++) mem1[i] = 32'd0;
      mem1[4] = 32'hDEADBEEF;
      mem1[8] = 32'h0BADF00D;
      repeat (2) @(negedge clk);
      checkOutput("rst_ready", 32'(bus1.MIO_ready), 32'd0);
      checkOutput("rst_data_in", bus1.Data_in, 32'd0);
      checkOutput("rst_strobes", {28'd0, ram_en1, ram_we1, io_en1, io_we1}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // RAM load with default single wait cycle
      log1.delete();
      applyStimulus(1, 1'b0, 32'h0000_0010, 32'd0, 32'hDEADBEEF, 1, 1'b0);
      checkOutput("ram_load_strobes", 32'(log1.size()), 32'd1);
      if (log1.size() == 1) begin
         checkOutput("ram_load_region", 32'(log1[0].is_io), 32'd0);
         checkOutput("ram_load_addr", log1[0].addr, 32'd4);
         checkOutput("ram_load_we", 32'(log1[0].we), 32'd0);
      end

      // IO store: Data_in must be 0 even though io_rdata is busy
      log1.delete();
      io_rdata1 = 32'h1234_5678;
      applyStimulus(1, 1'b1, 32'hE000_0004, 32'h0000_00A5, 32'd0, 3, 1'b0);
      checkOutput("io_store_strobes", 32'(log1.size()), 32'd1);
      if (log1.size() == 1) begin
         checkOutput("io_store_region", 32'(log1[0].is_io), 32'd1);
         checkOutput("io_store_we", 32'(log1[0].we), 32'd1);
         checkOutput("io_store_addr", log1[0].addr, 32'hE000_0004);
         checkOutput("io_store_wdata", log1[0].wdata, 32'h0000_00A5);
      end

      // IO load from the 0xF region
      io_rdata1 = 32'hCAFE_F00D;
      applyStimulus(1, 1'b0, 32'hF000_0100, 32'd0, 32'hCAFE_F00D, 3, 1'b0);

      // CPU_MIO dropped during ACCESS: single-cycle MIO_ready
      applyStimulus(1, 1'b0, 32'h0000_0020, 32'd0, 32'h0BADF00D, 1, 1'b1);

      // Async reset during WAIT of an IO load
      drive_bus(1, 1'b1, 1'b0, 32'hE000_0010, 32'h0000_0077);
      repeat (2) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      checkOutput("abort_ready", 32'(bus1.MIO_ready), 32'd0);
      checkOutput("abort_data_in", bus1.Data_in, 32'd0);
      checkOutput("abort_strobes", {28'd0, ram_en1, ram_we1, io_en1, io_we1}, 32'd0);
      checkOutput("abort_io_addr", io_addr1, 32'd0);
      checkOutput("abort_io_wdata", io_wdata1, 32'd0);
      checkOutput("abort_ram_addr", 32'(ram_addr1), 32'd0);
      drive_bus(1, 1'b0, 1'b0, 32'd0, 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      checkOutput("abort_no_ready", 32'(bus1.MIO_ready), 32'd0);
      applyStimulus(1, 1'b0, 32'h0000_0010, 32'd0, 32'hDEADBEEF, 1, 1'b0);

      // Back-to-back RAM stores, second issued in the first idle cycle
      log1.delete();
      applyStimulus(1, 1'b1, 32'h0000_0008, 32'h1111_1111, 32'd0, 1, 1'b0);
      applyStimulus(1, 1'b1, 32'h0000_000C, 32'h2222_2222, 32'd0, 1, 1'b0);
      checkOutput("b2b_strobes", 32'(log1.size()), 32'd2);
      if (log1.size() == 2) begin
         checkOutput("b2b_addr0", log1[0].addr, 32'd2);
         checkOutput("b2b_addr1", log1[1].addr, 32'd3);
         checkOutput("b2b_wdata0", log1[0].wdata, 32'h1111_1111);
         checkOutput("b2b_we1", 32'(log1[1].we), 32'd1);
      end
      applyStimulus(1, 1'b0, 32'h0000_0008, 32'd0, 32'h1111_1111, 1, 1'b0);
      applyStimulus(1, 1'b0, 32'h0000_000E, 32'd0, 32'h2222_2222, 1, 1'b0);

      // RAM_WAIT = 0 instance behaves as one wait cycle
      applyStimulus(2, 1'b0, 32'h0000_0014, 32'd0, 32'h5A5A_0005, 1, 1'b0);

      repeat (3) @(negedge clk);
      checkOutput("dut1_scoreboard_empty", 32'(exp_q1.size()), 32'd0);
      checkOutput("dut2_scoreboard_empty", 32'(exp_q2.size()), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/mio_responder.md
Name: mio_responder

Overview:
- Memory/IO bus responder on the far end of the controller's CPU_MIO / MIO_ready handshake.
- Accepts one load/store request at a time from the CPU controller and decodes the address to either data RAM or the peripheral (IO) region.
- Drives the target with a single access strobe, inserts a per-region number of wait states, then returns read data and MIO_ready using a 4-phase handshake.

Parameters:
- RAM_AW, 10, RAM word-address width (ram_addr = addr_bus[RAM_AW+1:2]).
- RAM_WAIT, 1, wait cycles after the RAM strobe; values below 1 are treated as 1 (RAM read latency is one cycle).
- IO_WAIT, 3, wait cycles after the IO strobe; values below 1 are treated as 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- CPU_MIO  in  1  request from the CPU controller; held high until MIO_ready is seen.
- mem_w  in  1  1 = store, 0 = load; sampled at accept.
- addr_bus  in  32  byte address; sampled at accept.
- Data_out  in  32  CPU store data; sampled at accept.
- Data_in  out  32  load data returned to the CPU; valid while MIO_ready = 1.
- MIO_ready  out  1  transaction-complete handshake.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  RAM write enable; only high together with ram_en.
- ram_addr  out  RAM_AW  RAM word address.
- ram_din  out  32  RAM write data.
- ram_dout  in  32  RAM read data, synchronous, one-cycle latency.
- io_en  out  1  IO access strobe.
- io_we  out  1  IO write enable.
- io_addr  out  32  full IO byte address.
- io_wdata  out  32  IO write data.
- io_rdata  in  32  IO read data; must be stable by the last wait cycle.

Behaviour:
- Reset (async, rst = 1):
  - State returns to IDLE.
  - All outputs go to 0: Data_in, MIO_ready, every strobe, every address and data output.
  - A reset mid-transaction aborts it. A strobe already issued is not retracted, and no MIO_ready is produced.
- Region decode, on the latched address:
  - addr[31:28] = 4'hE or 4'hF selects IO.
  - Any other value selects RAM.
  - addr[1:0] are ignored for RAM.
- FSM states: IDLE, ACCESS, WAIT, DONE. All outputs are registered.
- IDLE:
  - If CPU_MIO = 1, latch mem_w, addr_bus, Data_out and the region.
  - Load the wait counter with the region's wait value, then go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS (exactly 1 cycle):
  - Assert ram_en or io_en for the selected region only.
  - Assert the matching *_we = latched mem_w.
  - Address and data outputs hold their latched values from this cycle until the next accept.
  - Go to WAIT.
- WAIT (exactly N cycles, N = effective RAM_WAIT or IO_WAIT):
  - Strobes are low.
  - The counter decrements each cycle; the transition to DONE happens on the edge where the count reaches 0.
  - On that same edge, Data_in captures ram_dout or io_rdata for a load; for a store it is written 0.
- DONE:
  - MIO_ready = 1 and Data_in is held.
  - Stay in DONE while CPU_MIO = 1.
  - When CPU_MIO = 0, go to IDLE. MIO_ready drops on that edge, so the next IDLE cycle shows MIO_ready = 0.
- Latency: CPU_MIO sampled high in cycle 0 gives MIO_ready = 1 first in cycle 2+N (RAM default: 3, IO default: 5).
- CPU_MIO dropped during ACCESS/WAIT: the transaction still completes, and MIO_ready is high for exactly 1 cycle (DONE sees CPU_MIO = 0).
- Back-to-back requests: a new request is accepted only from IDLE, so there is a minimum of one MIO_ready = 0 cycle between transactions.
- Changes on addr_bus, Data_out or mem_w after accept have no effect on the transaction in flight.

Decomposition:
- Shared package mio_pkg:
  - State encoding localparams: IDLE = 2'd0, ACCESS = 2'd1, WAIT = 2'd2, DONE = 2'd3.
  - IO_REGION_HI = 3'b111 (compared against addr[31:29]).
- One natural sub-module, mio_wait_timer:
  - Loadable down-counter with a zero flag, width $clog2(max(RAM_WAIT, IO_WAIT) + 1).

Test Plan:
- RAM load, addr 0x0000_0010, ram_dout = 0xDEADBEEF, defaults:
  - ram_en pulses 1 cycle with ram_addr = 4 and ram_we = 0.
  - MIO_ready rises 3 cycles after accept with Data_in = 0xDEADBEEF.
  - MIO_ready drops the cycle after CPU_MIO falls.
- IO store, addr 0xE000_0004, Data_out = 0x0000_00A5:
  - io_en = io_we = 1 for one cycle, io_wdata = 0xA5, ram_en stays 0.
  - MIO_ready at cycle 5; Data_in = 0.
- CPU_MIO dropped one cycle after accept (RAM load): MIO_ready high for exactly 1 cycle at cycle 3, then IDLE.
- rst asserted asynchronously during WAIT of an IO load: all outputs 0 immediately, no MIO_ready. A new RAM load after release completes normally in 3 cycles.
- Two back-to-back RAM stores (addr 0x8, then 0xC): exactly 2 ram_en pulses (ram_addr 2, then 3), with at least one MIO_ready = 0 cycle between transactions.
- RAM_WAIT = 0 override: behaves as 1, i.e. MIO_ready at cycle 3 and Data_in equal to the correct ram_dout.
